// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed, active-low 4-digit seven-segment bus.
// Each scan slot is captured once it has been stable for SETTLE_CYCLES clocks.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        glyph_err,
    output logic        scan_err
);

    localparam logic [7:0] SETTLE_FULL = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_PREV = 8'(SETTLE_CYCLES - 1);

    logic [10:0] in_q, in_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_done_q, frame_done_d;
    logic        glyph_err_q, glyph_err_d;
    logic        scan_err_q, scan_err_d;

    logic [10:0] live;
    logic        stable;
    logic        capture;
    logic [3:0]  an_low;
    logic        one_low;
    logic [1:0]  slot;
    logic [3:0]  slot_mask;
    logic [3:0]  seen_set;
    logic        is_hex;
    logic        is_blank;
    logic [3:0]  code;

    // {hit, nibble}; hit is clear for blank and for any non-hex pattern
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        logic [4:0] r;
        r = '0;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        live   = {an, seg};
        stable = (live == in_q);
        in_d   = live;

        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q == SETTLE_FULL) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Saturation at SETTLE_FULL guarantees one capture per stable window
        capture = stable && (cnt_q == SETTLE_PREV);

        an_low  = ~an;
        one_low = (an_low != '0) && ((an_low & (an_low - 4'd1)) == '0);
        slot    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (an_low[i]) begin
                slot = 2'(i);
            end
        end
        slot_mask = 4'b0001 << slot;
        seen_set  = seen_q | slot_mask;

        {is_hex, code} = glyph_decode(seg);
        is_blank       = (seg == '1);

        digits_d     = digits_q;
        valid_d      = valid_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        glyph_err_d  = 1'b0;
        scan_err_d   = 1'b0;

        if (capture && one_low) begin
            if (is_hex) begin
                digits_d[{slot, 2'b00} +: 4] = code;
                valid_d[slot]                = 1'b1;
            end else if (is_blank) begin
                digits_d[{slot, 2'b00} +: 4] = '0;
                valid_d[slot]                = 1'b0;
            end else begin
                valid_d[slot] = 1'b0;
                glyph_err_d   = 1'b1;
            end
            if (seen_set == 4'b1111) begin
                frame_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_set;
            end
        end else if (capture && (an_low != '0)) begin
            scan_err_d = 1'b1;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            in_q         <= '1;
            cnt_q        <= '0;
            digits_q     <= '0;
            valid_q      <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            glyph_err_q  <= 1'b0;
            scan_err_q   <= 1'b0;
        end else begin
            in_q         <= in_d;
            cnt_q        <= cnt_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            seen_q       <= seen_d;
            frame_done_q <= frame_done_d;
            glyph_err_q  <= glyph_err_d;
            scan_err_q   <= scan_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign glyph_err   = glyph_err_q;
    assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: slot-table vectors with hand-derived results,
// reset/latency sequences, and random scan traffic against a run-length model.
module tb_seg_scan_decoder;

    localparam int SETTLE = 16;
    localparam int NV     = 24;

    logic        mclk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        glyph_err;
    logic        scan_err;

    always #5 mclk = ~mclk;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .glyph_err  (glyph_err),
        .scan_err   (scan_err)
    );

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          n;
        logic [15:0] exp_dig;
        logic [3:0]  exp_val;
        int          exp_fd;
        int          exp_ge;
        int          exp_se;
    } vec_t;

    vec_t tbl [NV];

    int tests = 0;
    int fails = 0;
    int fd_cnt, ge_cnt, se_cnt, fd_at;

    // Reference model: a capture happens on the edge where the same {an,seg}
    // has been seen on SETTLE+1 consecutive edges.
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_dig [4];
    bit          m_val [4];
    bit          m_seen [4];
    bit          m_fd, m_ge, m_se;

    function automatic int glyph_index(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph_tab[i] == s) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '1;
        m_run  = 1;
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = '0; m_val[k] = 0; m_seen[k] = 0;
        end
        m_fd = 0; m_ge = 0; m_se = 0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
        int lows, k, gi;
        m_fd = 0; m_ge = 0; m_se = 0;
        if ({a, s} == m_prev) m_run++;
        else m_run = 1;
        m_prev = {a, s};
        if (m_run == SETTLE + 1) begin
            lows = 0; k = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; k = i; end
            if (lows >= 2) begin
                m_se = 1;
            end else if (lows == 1) begin
                gi = glyph_index(s);
                if (gi >= 0) begin
                    m_dig[k] = 4'(gi); m_val[k] = 1;
                end else if (s == 7'h7F) begin
                    m_dig[k] = '0; m_val[k] = 0;
                end else begin
                    m_val[k] = 0; m_ge = 1;
                end
                m_seen[k] = 1;
                if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
                    m_fd = 1;
                    for (int j = 0; j < 4; j++) m_seen[j] = 0;
                end
            end
        end
    endtask

    function automatic logic [22:0] model_vec();
        logic [15:0] d;
        logic [3:0]  v;
        for (int k = 0; k < 4; k++) begin
            d[4*k +: 4] = m_dig[k];
            v[k]        = m_val[k];
        end
        return {d, v, m_fd, m_ge, m_se};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one clock with the given bus value and compare against the model.
    task automatic cycle(input logic [3:0] a, input logic [6:0] s);
        an  = a;
        seg = s;
        @(posedge mclk);
        #1;
        if (reset) model_reset();
        else model_edge(a, s);
        check("cycle", {9'd0, digits, digit_valid, frame_done, glyph_err, scan_err}, {9'd0, model_vec()});
        if (frame_done) fd_cnt++;
        if (glyph_err)  ge_cnt++;
        if (scan_err)   se_cnt++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        for (int j = 0; j < n; j++) cycle(a, s);
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 7'b1111111, 20, 16'h0000, 4'b0000, 0, 0, 0};
        tbl[1]  = '{4'b1110, 7'b0100100, 20, 16'h0002, 4'b0001, 0, 0, 0};
        tbl[2]  = '{4'b1101, 7'b0110000, 20, 16'h0032, 4'b0011, 0, 0, 0};
        tbl[3]  = '{4'b1011, 7'b0011001, 20, 16'h0432, 4'b0111, 0, 0, 0};
        tbl[4]  = '{4'b0111, 7'b0010010, 20, 16'h5432, 4'b1111, 1, 0, 0};
        tbl[5]  = '{4'b1110, 7'b1111001, 16, 16'h5432, 4'b1111, 0, 0, 0};
        tbl[6]  = '{4'b1111, 7'b1111111, 20, 16'h5432, 4'b1111, 0, 0, 0};
        tbl[7]  = '{4'b1110, 7'b1111001, 17, 16'h5431, 4'b1111, 0, 0, 0};
        tbl[8]  = '{4'b1110, 7'b1110111, 20, 16'h5431, 4'b1110, 0, 1, 0};
        tbl[9]  = '{4'b1110, 7'b1111111, 20, 16'h5430, 4'b1110, 0, 0, 0};
        tbl[10] = '{4'b1100, 7'b0000000, 20, 16'h5430, 4'b1110, 0, 0, 1};
        tbl[11] = '{4'b1111, 7'b1111111, 20, 16'h5430, 4'b1110, 0, 0, 0};
        tbl[12] = '{4'b1101, 7'b1000000, 20, 16'h5400, 4'b1110, 0, 0, 0};
        tbl[13] = '{4'b1011, 7'b0001000, 20, 16'h5A00, 4'b1110, 0, 0, 0};
        tbl[14] = '{4'b0111, 7'b0001110, 20, 16'hFA00, 4'b1110, 1, 0, 0};
        tbl[15] = '{4'b1110, 7'b0000000, 20, 16'hFA08, 4'b1111, 0, 0, 0};
        tbl[16] = '{4'b1101, 7'b1111111, 20, 16'hFA08, 4'b1101, 0, 0, 0};
        tbl[17] = '{4'b1011, 7'b1000110, 20, 16'hFC08, 4'b1101, 0, 0, 0};
        tbl[18] = '{4'b0111, 7'b1110111, 20, 16'hFC08, 4'b0101, 1, 1, 0};
        tbl[19] = '{4'b0111, 7'b0010000, 20, 16'h9C08, 4'b1101, 0, 0, 0};
        tbl[20] = '{4'b0111, 7'b0000011, 20, 16'hBC08, 4'b1101, 0, 0, 0};
        tbl[21] = '{4'b1011, 7'b0100001, 20, 16'hBD08, 4'b1101, 0, 0, 0};
        tbl[22] = '{4'b1101, 7'b0000110, 20, 16'hBDE8, 4'b1111, 0, 0, 0};
        tbl[23] = '{4'b1110, 7'b0000010, 20, 16'hBDE6, 4'b1111, 1, 0, 0};

        an    = '1;
        seg   = '1;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_state", {9'd0, digits, digit_valid, frame_done, glyph_err, scan_err}, 32'd0);
        @(posedge mclk);
        #1;
        @(posedge mclk);
        #1;
        reset = 1'b0;

        for (int t = 0; t < NV; t++) begin
            fd_cnt = 0; ge_cnt = 0; se_cnt = 0; fd_at = -1;
            for (int j = 0; j < tbl[t].n; j++) begin
                cycle(tbl[t].an, tbl[t].seg);
                if (frame_done && fd_at < 0) fd_at = j;
            end
            check($sformatf("vec%0d digits", t), {16'd0, digits}, {16'd0, tbl[t].exp_dig});
            check($sformatf("vec%0d valid", t), {28'd0, digit_valid}, {28'd0, tbl[t].exp_val});
            check($sformatf("vec%0d frame_done", t), fd_cnt, tbl[t].exp_fd);
            check($sformatf("vec%0d glyph_err", t), ge_cnt, tbl[t].exp_ge);
            check($sformatf("vec%0d scan_err", t), se_cnt, tbl[t].exp_se);
            if (tbl[t].exp_fd > 0) check($sformatf("vec%0d fd_latency", t), fd_at, SETTLE);
        end

        // Reset while the third slot of a frame is settling
        hold(4'b1110, glyph_tab[7], 20);
        hold(4'b1101, glyph_tab[8], 20);
        hold(4'b1011, glyph_tab[9], 8);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", {9'd0, digits, digit_valid, frame_done, glyph_err, scan_err}, 32'd0);
        hold(4'b1011, glyph_tab[9], 3);
        reset  = 1'b0;
        fd_cnt = 0; ge_cnt = 0; se_cnt = 0;
        hold(4'b1011, glyph_tab[9], 20);
        hold(4'b1110, glyph_tab[1], 20);
        hold(4'b0111, glyph_tab[4], 20);
        hold(4'b1101, glyph_tab[2], 20);
        check("post_reset digits", {16'd0, digits}, 32'h4921);
        check("post_reset valid", {28'd0, digit_valid}, 32'hF);
        check("post_reset frames", fd_cnt, 1);
        check("post_reset errors", ge_cnt + se_cnt, 0);

        // Random scan traffic: mostly single-anode slots, some idle, some
        // overlapping anodes, a mix of glyphs, blanks and junk, varied widths
        for (int r = 0; r < 150; r++) begin
            logic [3:0] a;
            logic [6:0] s;
            int kind, sk;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) a = 4'b1111;
            else if (kind == 1) a = ~(4'b0011 << $urandom_range(0, 2));
            else a = ~(4'b0001 << $urandom_range(0, 3));
            sk = int'($urandom_range(0, 9));
            if (sk < 7) s = glyph_tab[$urandom_range(0, 15)];
            else if (sk == 7) s = 7'h7F;
            else s = 7'($urandom);
            hold(a, s, int'($urandom_range(1, 30)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the multiplexed 4-digit seven-segment drive produced by `Display_Top`. Watches the active-low `an`/`seg` bus, waits for each scan slot to settle, decodes the glyph back to a hex nibble and rebuilds the four displayed digits. It sits beside `Display_Top` in self-checking benches and on-board loopback checks, so digit values can be compared directly instead of through `$monitor` traces.

## Interface
- `SETTLE_CYCLES`, default 16: consecutive `mclk` cycles `{an,seg}` must hold before a slot is captured; legal range 2..255.
- `mclk`  input  1  system clock, 100 MHz; all state on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `seg`  input  7  active-low segments, `seg[0]`=a … `seg[6]`=g.
- `an`  input  4  active-low anodes, `an[0]`=rightmost digit.
- `digits`  output  16  decoded nibbles; digit k at `[4k+3:4k]`.
- `digit_valid`  output  4  bit k set when digit k holds a decoded hex glyph.
- `frame_done`  output  1  one-cycle pulse when all four slots have been captured since the last pulse.
- `glyph_err`  output  1  one-cycle pulse: captured pattern is neither a hex glyph nor blank.
- `scan_err`  output  1  one-cycle pulse: captured `an` has more than one low bit.

## Operation
- Glyph table (`seg` as g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blank=1111111.
- Input register `in_q` holds `{an,seg}` every cycle. Settle counter `cnt` (8 bit) goes to 0 when live `{an,seg}` differs from `in_q`, otherwise increments and saturates at `SETTLE_CYCLES`.
- Capture fires once per stable window, on the edge where `cnt` goes from `SETTLE_CYCLES-1` to `SETTLE_CYCLES`. Any change restarts the window. There is no second capture while the window stays stable.
- Capture classification, using the captured `an`:
  - `an`=1111 (idle or blanking gap): no action, no flags.
  - Exactly one low bit at index k, hex glyph: `digits[k]` <= code, `digit_valid[k]` <= 1, `seen[k]` <= 1.
  - Exactly one low bit at index k, blank: `digits[k]` <= 0, `digit_valid[k]` <= 0, `seen[k]` <= 1, no error.
  - Exactly one low bit at index k, any other pattern: `digits[k]` unchanged, `digit_valid[k]` <= 0, `seen[k]` <= 1, `glyph_err` pulses.
  - Two or more low bits: `scan_err` pulses. No digit, valid or seen update.
- Frame tracking, with internal 4-bit `seen` mask:
  - When a capture would make `seen`=1111, `frame_done` pulses on that same edge and `seen` clears to 0000.
  - Capturing the same slot twice in one frame overwrites the digit and does not advance the frame.

## Timing
- Reset values (asynchronous, immediate): `digits`=0, `digit_valid`=0000, `frame_done`=0, `glyph_err`=0, `scan_err`=0, `seen`=0000, `cnt`=0, `in_q`=all ones (idle).
- Latency: a new `{an,seg}` value is first sampled at edge E0. If it is held through edge E_SETTLE, outputs update at E_SETTLE, i.e. `SETTLE_CYCLES` cycles after E0.
- A slot shorter than `SETTLE_CYCLES+1` edges is ignored silently.
- All pulses are exactly one cycle wide. `glyph_err` and `frame_done` can assert on the same edge.
- Reset asserted mid-window: all state is lost. After reset deasserts, a full new settle window is required, even if the inputs never changed.
- A scan order other than 0-1-2-3 is legal; only set membership matters for `frame_done`.

## Test plan
- Drive slots an=1110/seg=0100100, then 1101/0110000, 1011/0011001, 0111/0010010, each 20 cycles with SETTLE=16 -> `digits`=0x5432, `digit_valid`=1111, one `frame_done` pulse exactly 16 cycles after the last slot's first sampled edge.
- Hold an=1110/seg=1111001 for exactly 16 edges, then change -> no capture. Hold for 17 edges -> `digits[3:0]`=1, capture on the 17th edge.
- an=1110 with seg=1110111 -> `glyph_err` pulse, `digit_valid[0]`=0, `digits[3:0]` unchanged. Same slot with seg=1111111 -> no error, nibble 0, valid 0.
- an=1100, any seg, stable 20 cycles -> `scan_err` single pulse, `digits`/`digit_valid` unchanged. an=1111 stable -> no flags.
- Assert `reset` for 3 cycles while the third slot of a frame is settling -> all outputs 0 immediately. The next full 4-slot sweep yields exactly one `frame_done`.
- Instantiate with `Display_Top` at 100 MHz for 500 us after a 50 ns reset -> every decoded frame matches the value `Display_Top` is commanded to show, and `glyph_err`/`scan_err` never assert.
